// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_t  : controller states (IDLE, RUN, DONE)
//   cnt_w()  : width of the bit counter for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit beyond $clog2 so the count stays representable at WIDTH=1.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: combinational one-bit full subtractor, x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: WIDTH-bit a - b computed LSB first, one bit per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start        : launch request, honoured only in IDLE; a/b captured then
//   a, b         : minuend, subtrahend
//   busy         : high while bits are being processed (RUN)
//   done         : one-cycle pulse, diff/borrow(/ovf) valid
//   diff, borrow : registered result and final borrow (1 iff a < b unsigned)
//   ovf          : signed overflow, only when SERIAL_SUB_OVF_EN is defined
// Results are held until the next operation completes or reset.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br, d, bout;
  logic             accept, last;

  full_subtractor_cell u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (br),
    .d   (d),
    .bout(bout)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = d;
    end else begin : g_wn
      assign res_nxt = {d, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      cnt    <= cnt + 1'b1;
      br     <= bout;
      if (last) begin
        diff   <= res_nxt;
        borrow <= bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Sign bits are kept apart because a_sh/b_sh lose them while shifting.
  logic sa, sb;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa  <= 1'b0;
      sb  <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      sa <= a[WIDTH-1];
      sb <= b[WIDTH-1];
    end else if (last) begin
      ovf <= (sa != sb) && (d != sa);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: one WIDTH=8 and one WIDTH=1 instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, diff8;
  logic [0:0] a1, b1, diff1;
  logic       busy8, done8, borrow8, busy1, done1, borrow1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf8),
`endif
    .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf1),
`endif
    .borrow(borrow1)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Launch on WIDTH=8 from a falling edge in IDLE. edges counts clock edges
  // from the accepting edge (inclusive) to the one that raises done.
  // At edge number ign (if >0) a second start with other operands is pulsed.
  // Returns on the falling edge of the first IDLE cycle after done.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input int ign,
                      output int edges, output int busy_n);
    start8 = 1'b1; a8 = ta; b8 = tb;
    @(posedge clk);
    edges = 1; busy_n = 0;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
    while (!done8 && edges < 40) begin
      if (busy8) busy_n++;
      if (edges == ign) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      else              begin start8 = 1'b0; end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start8 = 1'b0;
    if (!done8) chk("run8_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("run8_done_1cyc", done8, 0);
  endtask

  task automatic run1(input logic ta, input logic tb, output int edges);
    start1 = 1'b1; a1 = ta; b1 = tb;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start1 = 1'b0;
    while (!done1 && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done1) chk("run1_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  int e, bn, extra;
  logic [7:0] va [4] = '{8'h03, 8'hFF, 8'h00, 8'h10};
  logic [7:0] vb [4] = '{8'h05, 8'h01, 8'h00, 8'h01};
  logic [7:0] vd [4] = '{8'hFE, 8'hFE, 8'h00, 8'h0F};
  logic       vbr[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; start8 = 0; start1 = 0; a8 = 0; b8 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", borrow8, 0);
    chk("rst_w1", {busy1, done1, diff1, borrow1}, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf8, 0);
`endif
    rst = 1'b0;

    // Basic op with latency and busy length.
    run8(8'h05, 8'h03, 0, e, bn);
    chk("lat_edges", e, 9);
    chk("busy_cycles", bn, 8);
    chk("d05_03", diff8, 8'h02);
    chk("b05_03", borrow8, 0);

    // Back-to-back directed vectors.
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], 0, e, bn);
      chk($sformatf("diff_v%0d", i), diff8, vd[i]);
      chk($sformatf("borrow_v%0d", i), borrow8, vbr[i]);
      chk($sformatf("lat_v%0d", i), e, 9);
    end

    // Start during RUN is ignored and not queued.
    run8(va[3], vb[3], 3, e, bn);
    chk("ign_diff", diff8, vd[3]);
    chk("ign_borrow", borrow8, vbr[3]);
    chk("ign_lat", e, 9);
    extra = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("ign_no_second_op", extra, 0);

    // Reset mid-RUN; result held during RUN before reset.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("hold_in_run", diff8, 8'h0F);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy8, 0);
    chk("mrst_done", done8, 0);
    chk("mrst_diff", diff8, 0);
    chk("mrst_borrow", borrow8, 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("mrst_no_done", extra, 0);
    run8(8'h09, 8'h04, 0, e, bn);
    chk("post_rst_diff", diff8, 8'h05);
    chk("post_rst_borrow", borrow8, 0);

    // WIDTH=1 half-subtractor table.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      run1(ab[1], ab[0], e);
      chk($sformatf("w1_diff_%0d", i), diff1, ab[1] ^ ab[0]);
      chk($sformatf("w1_borrow_%0d", i), borrow1, ~ab[1] & ab[0]);
      chk($sformatf("w1_lat_%0d", i), e, 2);
    end

`ifdef SERIAL_SUB_OVF_EN
    run8(8'h80, 8'h01, 0, e, bn);
    chk("ovf_80_01_diff", diff8, 8'h7F);
    chk("ovf_80_01", ovf8, 1);
    run8(8'h7F, 8'hFF, 0, e, bn);
    chk("ovf_7f_ff_diff", diff8, 8'h80);
    chk("ovf_7f_ff", ovf8, 1);
    chk("ovf_7f_ff_borrow", borrow8, 1);
    run8(8'h05, 8'h03, 0, e, bn);
    chk("ovf_05_03", ovf8, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
